// File: rtl/f_pc_seq_if.sv
// Instruction-memory fetch port: request/address out, ready/data back in the same cycle.
interface f_pc_seq_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (output imem_req, imem_addr, input imem_ready, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_ready, imem_rdata);
endinterface

// File: rtl/f_pc_seq.sv
// Fetch-stage PC sequencer: IDLE/FETCH/HOLD handshake with delay-slot redirects,
// address-error flagging and a consumed-fetch counter.
module f_pc_seq #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] PC_LO    = 32'h0000_3000,
  parameter logic [31:0] PC_HI    = 32'h0000_6FFC
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              npc_redirect,
  input  logic [31:0]       npc,
  f_pc_seq_if.master        imem,
  output logic [31:0]       F_PC,
  output logic [31:0]       F_Instr,
  output logic              F_valid,
  output logic              F_AdEL,
  output logic [31:0]       F_cnt
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

  state_t      state, state_nxt;
  logic [31:0] instr_q;
  logic [31:0] redir_tgt;
  logic        redir_pend;
  logic        legal;
  logic        advance;
  logic [31:0] pc_nxt;

  assign legal = (F_PC[1:0] == 2'b00) && (F_PC >= PC_LO) && (F_PC <= PC_HI);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = FETCH;
      FETCH:   if (!legal || imem.imem_ready) state_nxt = HOLD;
      HOLD:    if (advance) state_nxt = FETCH;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    imem.imem_req  = (state == FETCH) && legal;
    imem.imem_addr = F_PC;
    F_valid        = (state == HOLD);
    advance        = (state == HOLD) && !stall;
    F_Instr        = (state == HOLD) ? instr_q : 32'h0;
  end

  // A redirect seen in the advance cycle beats any older pending one.
  always_comb begin
    if (npc_redirect)    pc_nxt = npc;
    else if (redir_pend) pc_nxt = redir_tgt;
    else                 pc_nxt = F_PC + 32'd4;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      F_PC       <= RESET_PC;
      instr_q    <= 32'h0;
      F_AdEL     <= 1'b0;
      F_cnt      <= 32'h0;
      redir_pend <= 1'b0;
      redir_tgt  <= 32'h0;
    end else begin
      if (state == FETCH) begin
        if (!legal) begin
          instr_q <= 32'h0;
          F_AdEL  <= 1'b1;
        end else if (imem.imem_ready) begin
          instr_q <= imem.imem_rdata;
          F_AdEL  <= 1'b0;
        end
      end
      if (advance) begin
        F_PC       <= pc_nxt;
        F_cnt      <= F_cnt + 32'd1;
        redir_pend <= 1'b0;
      end else if (npc_redirect) begin
        redir_pend <= 1'b1;
        redir_tgt  <= npc;
      end
    end
  end

endmodule

// File: tb/tb_f_pc_seq.sv
// Directed bench for f_pc_seq; memory returns addr ^ 0xA5A5_0000 so every word is traceable.
module tb_f_pc_seq;
  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        npc_redirect;
  logic [31:0] npc;
  logic [31:0] F_PC, F_Instr, F_cnt;
  logic        F_valid, F_AdEL;
  int          n_assert = 0;
  int          n_fail = 0;

  f_pc_seq_if imem_if ();

  f_pc_seq dut (
    .clk(clk), .reset(reset), .stall(stall), .npc_redirect(npc_redirect), .npc(npc),
    .imem(imem_if.master), .F_PC(F_PC), .F_Instr(F_Instr), .F_valid(F_valid),
    .F_AdEL(F_AdEL), .F_cnt(F_cnt)
  );

  always #5 clk = ~clk;
  assign imem_if.imem_rdata = imem_if.imem_addr ^ 32'hA5A5_0000;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // req, valid, pc, instr, adel, cnt in one shot
  task automatic chk_all(input string tag, input logic req, input logic vld, input logic [31:0] pc,
                         input logic [31:0] ins, input logic adel, input logic [31:0] cnt);
    chk({tag, ".req"},   {31'b0, imem_if.imem_req}, {31'b0, req});
    chk({tag, ".vld"},   {31'b0, F_valid}, {31'b0, vld});
    chk({tag, ".pc"},    F_PC, pc);
    chk({tag, ".addr"},  imem_if.imem_addr, pc);
    chk({tag, ".instr"}, F_Instr, ins);
    chk({tag, ".adel"},  {31'b0, F_AdEL}, {31'b0, adel});
    chk({tag, ".cnt"},   F_cnt, cnt);
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; npc_redirect = 1'b0; npc = 32'h0;
    imem_if.imem_ready = 1'b1;
    #1;
    chk_all("rst", 0, 0, 32'h3000, 32'h0, 0, 0);
    step();
    reset = 1'b0;

    // Back-to-back fetches, two cycles each
    step(); chk_all("f0",  1, 0, 32'h3000, 32'h0, 0, 0);
    step(); chk_all("h0",  0, 1, 32'h3000, 32'hA5A5_3000, 0, 0);
    step(); chk_all("f1",  1, 0, 32'h3004, 32'h0, 0, 1);
    step(); chk_all("h1",  0, 1, 32'h3004, 32'hA5A5_3004, 0, 1);
    step(); chk_all("f2",  1, 0, 32'h3008, 32'h0, 0, 2);
    step(); chk_all("h2",  0, 1, 32'h3008, 32'hA5A5_3008, 0, 2);
    step(); chk_all("f3",  1, 0, 32'h300C, 32'h0, 0, 3);

    // Memory wait states: request and address must stay put
    imem_if.imem_ready = 1'b0;
    chk_all("w0", 1, 0, 32'h300C, 32'h0, 0, 3);
    for (int i = 1; i < 5; i++) begin
      step(); chk_all("wN", 1, 0, 32'h300C, 32'h0, 0, 3);
    end
    imem_if.imem_ready = 1'b1;
    step(); chk_all("h3", 0, 1, 32'h300C, 32'hA5A5_300C, 0, 3);

    // Stall in HOLD freezes everything
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(); chk_all("stl", 0, 1, 32'h300C, 32'hA5A5_300C, 0, 3);
    end
    stall = 1'b0;
    step(); chk_all("f4", 1, 0, 32'h3010, 32'h0, 0, 4);

    // Reset while waiting in FETCH; late ready ignored
    imem_if.imem_ready = 1'b0;
    step(); chk_all("w10", 1, 0, 32'h3010, 32'h0, 0, 4);
    reset = 1'b1;
    #1; chk_all("arst", 0, 0, 32'h3000, 32'h0, 0, 0);
    imem_if.imem_ready = 1'b1;
    step(); chk_all("arst2", 0, 0, 32'h3000, 32'h0, 0, 0);
    reset = 1'b0;
    step(); chk_all("rf0", 1, 0, 32'h3000, 32'h0, 0, 0);
    step(); chk_all("rh0", 0, 1, 32'h3000, 32'hA5A5_3000, 0, 0);
    step(); chk_all("rf1", 1, 0, 32'h3004, 32'h0, 0, 1);

    // Redirect during FETCH of 0x3004: delay slot still delivered
    npc_redirect = 1'b1; npc = 32'h3100;
    step(); chk_all("ds", 0, 1, 32'h3004, 32'hA5A5_3004, 0, 1);
    npc_redirect = 1'b0; npc = 32'h0;
    step(); chk_all("rd1", 1, 0, 32'h3100, 32'h0, 0, 2);
    step(); chk_all("rh1", 0, 1, 32'h3100, 32'hA5A5_3100, 0, 2);

    // Redirect raised in the advance cycle itself
    npc_redirect = 1'b1; npc = 32'h3200;
    step(); chk_all("rd2", 1, 0, 32'h3200, 32'h0, 0, 3);
    npc_redirect = 1'b0;
    step(); chk_all("rh2", 0, 1, 32'h3200, 32'hA5A5_3200, 0, 3);

    // Pending redirect while stalled; latest target wins (misaligned)
    stall = 1'b1; npc_redirect = 1'b1; npc = 32'h1234_5678;
    step(); chk_all("pnd0", 0, 1, 32'h3200, 32'hA5A5_3200, 0, 3);
    npc = 32'h3002;
    step(); chk_all("pnd1", 0, 1, 32'h3200, 32'hA5A5_3200, 0, 3);
    stall = 1'b0; npc_redirect = 1'b0;
    step(); chk_all("bad0f", 0, 0, 32'h3002, 32'h0, 0, 4);
    step(); chk_all("bad0h", 0, 1, 32'h3002, 32'h0, 1, 4);

    // Above PC_HI
    npc_redirect = 1'b1; npc = 32'h7000;
    step(); chk_all("bad1f", 0, 0, 32'h7000, 32'h0, 1, 5);
    npc_redirect = 1'b0;
    step(); chk_all("bad1h", 0, 1, 32'h7000, 32'h0, 1, 5);

    // Below PC_LO
    npc_redirect = 1'b1; npc = 32'h2FFC;
    step(); chk_all("bad2f", 0, 0, 32'h2FFC, 32'h0, 1, 6);
    npc_redirect = 1'b0;
    step(); chk_all("bad2h", 0, 1, 32'h2FFC, 32'h0, 1, 6);

    // PC_HI itself is legal and clears the error flag
    npc_redirect = 1'b1; npc = 32'h6FFC;
    step(); chk_all("hif", 1, 0, 32'h6FFC, 32'h0, 1, 7);
    npc_redirect = 1'b0;
    step(); chk_all("hih", 0, 1, 32'h6FFC, 32'hA5A5_6FFC, 0, 7);
    step(); chk_all("wrapf", 0, 0, 32'h7000, 32'h0, 0, 8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/f_pc_seq.md
F_PC_SEQ -- requirements
Module: f_pc_seq

Interface
REQ-001 Params: RESET_PC, default 32'h0000_3000, fetch start address; PC_LO, default 32'h0000_3000, lowest legal fetch address; PC_HI, default 32'h0000_6FFC, highest legal fetch address.
REQ-002 clk  in  1  the single clock, rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 stall  in  1  hazard-unit freeze of F/D; the fetched word is not consumed while it is 1.
REQ-005 npc_redirect  in  1  D-stage taken jump/branch, level, held while D is stalled.
REQ-006 npc  in  32  redirect target from the D-stage next-PC logic; valid when npc_redirect=1.
REQ-007 imem_ready  in  1  instruction memory acknowledge; imem_rdata is valid in the same cycle.
REQ-008 imem_rdata  in  32  instruction word.
REQ-009 imem_req  out  1  fetch request.
REQ-010 imem_addr  out  32  fetch address, always equal to F_PC.
REQ-011 F_PC  out  32  PC of the word in flight or held.
REQ-012 F_Instr  out  32  captured instruction; 0 (nop) when F_valid=0 or on a bad address.
REQ-013 F_valid  out  1  F_Instr/F_PC present a consumable fetch.
REQ-014 F_AdEL  out  1  held fetch has an illegal address.
REQ-015 F_cnt  out  32  count of consumed fetches.

Function
REQ-016 FSM states: IDLE, FETCH, HOLD; state register is the only source of imem_req and F_valid, both decoded from state.
REQ-017 IDLE: imem_req=0, F_valid=0; next state FETCH unconditionally (one cycle after reset release).
REQ-018 FETCH, legal address (F_PC[1:0]=0, PC_LO<=F_PC<=PC_HI): imem_req=1; if imem_ready=1, F_Instr<=imem_rdata, F_AdEL<=0, go HOLD; otherwise stay, with imem_req and imem_addr stable.
REQ-019 FETCH, illegal address: imem_req=0; go HOLD next cycle with F_Instr<=0 and F_AdEL<=1.
REQ-020 HOLD: F_valid=1; advance = F_valid & ~stall.
REQ-021 On advance: F_PC<=next PC; F_cnt<=F_cnt+1 (wraps mod 2^32); go FETCH; clear the pending redirect.
REQ-022 Next PC priority: npc_redirect=1 in the advance cycle gives npc; otherwise a pending redirect gives redir_tgt; otherwise F_PC+4 (mod 2^32).
REQ-023 Pending redirect: npc_redirect=1 in any non-advance cycle sets redir_pend<=1 and redir_tgt<=npc; the latest value wins.
REQ-024 Delay-slot semantics: a redirect never discards the word currently in FETCH or HOLD; it applies only to the PC after that word.
REQ-025 stall has no effect in IDLE or FETCH; the memory handshake completes regardless.
REQ-026 Latency: with imem_ready tied to 1 and stall=0, one fetch is consumed every 2 cycles (FETCH, HOLD).

Reset
REQ-027 On reset assertion, without waiting for a clock edge: state=IDLE, F_PC=RESET_PC, F_Instr=0, F_AdEL=0, F_cnt=0, redir_pend=0, redir_tgt=0, imem_req=0, F_valid=0.
REQ-028 A reset asserted mid-FETCH drops imem_req immediately; a late imem_ready is ignored.

Verification
REQ-029 Reset release, imem_ready=1, stall=0 -> imem_addr 0x3000, 0x3004, 0x3008 on alternate cycles; F_cnt=3 after the third HOLD.
REQ-030 imem_ready held low for 5 cycles in FETCH -> imem_req=1 and imem_addr constant for 5 cycles; HOLD is entered on the cycle after imem_ready rises.
REQ-031 HOLD with stall=1 for 4 cycles -> F_PC, F_Instr and F_valid unchanged, F_cnt unchanged; advance occurs on the first cycle with stall=0.
REQ-032 npc_redirect=1 with npc=0x3100 during FETCH of 0x3004 -> 0x3004 is still delivered, then the next fetch is at 0x3100; the redirect asserted in the advance cycle itself gives the same result.
REQ-033 Redirect to 0x3002, then to 0x7000 -> each target sees imem_req=0, F_valid=1, F_AdEL=1 and F_Instr=0; 0x2FFC is likewise rejected.
REQ-034 Assert reset while waiting in FETCH at 0x3010 -> outputs reach reset values the same cycle; the first request after release is at 0x3000.
